// File: rtl/upstream_pkg.sv
// Shared definitions for the upstream order path: controller states and the
// default bus widths also used by downstream_top.
package upstream_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        SETTLE,
        REPORT
    } state_t;

endpackage

// File: rtl/upstream_order_tx_if.sv
// Order request, downstream write/readback and response signals of upstream_order_tx.
// The master side is whoever feeds orders and consumes responses; the block is the slave.
interface upstream_order_tx_if
    import upstream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_client_id;
    logic [DATA_WIDTH-1:0] in_amount;
    logic                  memwr;
    logic [ADDR_WIDTH-1:0] client_id;
    logic [DATA_WIDTH-1:0] amount;
    logic [DATA_WIDTH-1:0] cancelled_orders;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ADDR_WIDTH-1:0] resp_client_id;
    logic [DATA_WIDTH-1:0] resp_cancelled;

    modport master (
        output in_valid, in_client_id, in_amount, cancelled_orders, resp_ready,
        input  in_ready, memwr, client_id, amount, resp_valid, resp_client_id, resp_cancelled
    );

    modport slave (
        input  in_valid, in_client_id, in_amount, cancelled_orders, resp_ready,
        output in_ready, memwr, client_id, amount, resp_valid, resp_client_id, resp_cancelled
    );

endinterface

// File: rtl/upstream_order_tx_fifo.sv
// order_fifo: power-of-two deep buffer of pending orders with synchronous reset.
// Head entry is presented combinationally on pop_data.
module order_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/upstream_order_tx.sv
// Buffers client orders and issues them one at a time to downstream_top, then reports
// the sampled cancelled_orders. Define UPSTREAM_ORDER_TX_STATS_EN to add sent/dropped counters.
module upstream_order_tx
    import upstream_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    upstream_order_tx_if.slave bus,
    output logic               busy
`ifdef UPSTREAM_ORDER_TX_STATS_EN
    ,
    output logic [31:0]        orders_sent,
    output logic [31:0]        orders_dropped
`endif
);

    localparam int         ORDER_WIDTH = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t                 state;
    state_t                 state_next;
    logic [ORDER_WIDTH-1:0] head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   issue_strobe;
    logic                   report_valid;
    logic [3:0]             settle_cnt;
    logic                   settle_last;
    logic [ADDR_WIDTH-1:0]  cur_client;
    logic [DATA_WIDTH-1:0]  cur_amount;
    logic [ADDR_WIDTH-1:0]  rsp_client;
    logic [DATA_WIDTH-1:0]  rsp_cancelled;

    // in_ready depends only on the buffer, so a full buffer refuses even while popping.
    assign push        = bus.in_valid && !fifo_full;
    assign settle_last = (settle_cnt == SETTLE_LAST);

    order_fifo #(
        .WIDTH (ORDER_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({bus.in_client_id, bus.in_amount}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifo_empty)    state_next = ISSUE;
            ISSUE:                       state_next = SETTLE;
            SETTLE:  if (settle_last)    state_next = REPORT;
            REPORT:  if (bus.resp_ready) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    always_comb begin
        pop          = 1'b0;
        issue_strobe = 1'b0;
        report_valid = 1'b0;
        case (state)
            IDLE:    pop          = !fifo_empty;
            ISSUE:   issue_strobe = 1'b1;
            REPORT:  report_valid = 1'b1;
            default: ;
        endcase
        busy = (state != IDLE) || !fifo_empty;
    end

    // The popped order stays on client_id/amount until the next pop replaces it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_client    <= '0;
            cur_amount    <= '0;
            rsp_client    <= '0;
            rsp_cancelled <= '0;
            settle_cnt    <= '0;
        end else begin
            if (pop) {cur_client, cur_amount} <= head;
            if (state == SETTLE) settle_cnt <= settle_cnt + 4'd1;
            else                 settle_cnt <= '0;
            if (state == SETTLE && settle_last) begin
                rsp_cancelled <= bus.cancelled_orders;
                rsp_client    <= cur_client;
            end
        end
    end

`ifdef UPSTREAM_ORDER_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            orders_sent    <= '0;
            orders_dropped <= '0;
        end else begin
            if (state == ISSUE)                orders_sent    <= orders_sent + 32'd1;
            if (bus.in_valid && fifo_full)     orders_dropped <= orders_dropped + 32'd1;
        end
    end
`endif

    assign bus.in_ready       = !fifo_full;
    assign bus.memwr          = issue_strobe;
    assign bus.client_id      = cur_client;
    assign bus.amount         = cur_amount;
    assign bus.resp_valid     = report_valid;
    assign bus.resp_client_id = rsp_client;
    assign bus.resp_cancelled = rsp_cancelled;

endmodule

// File: tb/tb_upstream_order_tx.sv
// Directed bench for upstream_order_tx: an order-queue model checked every cycle plus
// literal expectations for latency, ordering, backpressure and mid-flight reset.
module tb_upstream_order_tx;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    typedef struct packed {
        logic [AW-1:0] c;
        logic [DW-1:0] a;
    } ord_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [31:0] cyc = 32'd0;
    logic        cancel_sweep;
    logic [DW-1:0] cancel_const;
    int          checks = 0;
    int          passed = 0;
`ifdef UPSTREAM_ORDER_TX_STATS_EN
    logic [31:0] orders_sent;
    logic [31:0] orders_dropped;
    logic [31:0] m_sent;
    logic [31:0] m_dropped;
`endif

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 32'd1;

    upstream_order_tx_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    // cancelled_orders changes only on falling edges so the capture edge sees a stable value.
    assign bus.cancelled_orders = cancel_sweep ? {16'hCA00, cyc[15:0]} : cancel_const;

    upstream_order_tx #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .FIFO_DEPTH    (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .busy           (busy)
`ifdef UPSTREAM_ORDER_TX_STATS_EN
        ,
        .orders_sent    (orders_sent),
        .orders_dropped (orders_dropped)
`endif
    );

    // Transaction-level model: pending queue plus one in-flight order and its age in cycles.
    ord_t          mq[$];
    bit            model_valid = 1'b0;
    bit            m_inflight;
    int            m_age;
    logic [AW-1:0] m_client;
    logic [DW-1:0] m_amount;
    logic [AW-1:0] m_rclient;
    logic [DW-1:0] m_rcanc;

    always @(posedge clk) begin : model_update
        bit   accept;
        bit   start;
        ord_t o;
        if (reset) begin
            mq.delete();
            m_inflight  = 1'b0;
            m_age       = 0;
            m_client    = '0;
            m_amount    = '0;
            m_rclient   = '0;
            m_rcanc     = '0;
            model_valid = 1'b1;
`ifdef UPSTREAM_ORDER_TX_STATS_EN
            m_sent      = '0;
            m_dropped   = '0;
`endif
        end else begin
            accept = bus.in_valid && (mq.size() < DEPTH);
            start  = !m_inflight && (mq.size() > 0);
`ifdef UPSTREAM_ORDER_TX_STATS_EN
            if (bus.in_valid && !accept) m_dropped = m_dropped + 32'd1;
            if (m_inflight && m_age == 0) m_sent = m_sent + 32'd1;
`endif
            if (m_inflight) begin
                if (m_age <= SETTLE) begin
                    if (m_age == SETTLE) begin
                        m_rcanc   = bus.cancelled_orders;
                        m_rclient = m_client;
                    end
                    m_age = m_age + 1;
                end else if (bus.resp_ready) begin
                    m_inflight = 1'b0;
                end
            end
            if (start) begin
                o          = mq.pop_front();
                m_client   = o.c;
                m_amount   = o.a;
                m_inflight = 1'b1;
                m_age      = 0;
            end
            if (accept) mq.push_back('{c: bus.in_client_id, a: bus.in_amount});
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("in_ready",       bus.in_ready,       (mq.size() < DEPTH));
            checkOutput("memwr",          bus.memwr,          (m_inflight && m_age == 0));
            checkOutput("resp_valid",     bus.resp_valid,     (m_inflight && m_age > SETTLE));
            checkOutput("busy",           busy,               (m_inflight || mq.size() > 0));
            checkOutput("client_id",      bus.client_id,      m_client);
            checkOutput("amount",         bus.amount,         m_amount);
            checkOutput("resp_client_id", bus.resp_client_id, m_rclient);
            checkOutput("resp_cancelled", bus.resp_cancelled, m_rcanc);
`ifdef UPSTREAM_ORDER_TX_STATS_EN
            checkOutput("orders_sent",    orders_sent,        m_sent);
            checkOutput("orders_dropped", orders_dropped,     m_dropped);
`endif
        end
    end

    // Observed write pulses and accepted responses, for the ordering checks.
    ord_t issue_log[$];
    ord_t resp_log[$];

    always @(negedge clk) begin
        if (model_valid) begin
            if (bus.memwr === 1'b1) issue_log.push_back('{c: bus.client_id, a: bus.amount});
            if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1)
                resp_log.push_back('{c: bus.resp_client_id, a: bus.resp_cancelled});
        end
    end

    // Present one order and hold it until the block accepts it; returns just after the accepting edge.
    task automatic applyStimulus(input logic [AW-1:0] c, input logic [DW-1:0] a);
        int waited = 0;
        bus.in_valid     = 1'b1;
        bus.in_client_id = c;
        bus.in_amount    = a;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", bus.in_ready, 1'b1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: run did not complete, expected finish before 300000");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        reset            = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_client_id = '0;
        bus.in_amount    = '0;
        bus.resp_ready   = 1'b0;
        cancel_sweep     = 1'b0;
        cancel_const     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        checkOutput("rst_in_ready",   bus.in_ready,       1'b1);
        checkOutput("rst_memwr",      bus.memwr,          1'b0);
        checkOutput("rst_resp_valid", bus.resp_valid,     1'b0);
        checkOutput("rst_busy",       busy,               1'b0);
        checkOutput("rst_client_id",  bus.client_id,      '0);
        checkOutput("rst_resp_canc",  bus.resp_cancelled, '0);
        @(posedge clk);
        #1;

        // Single order: write strobe one cycle after acceptance, response SETTLE cycles later.
        $display("[TB] single order latency");
        cancel_const = 32'h7;
        applyStimulus(5'h01, 32'h1);
        @(negedge clk);
        checkOutput("t1_no_early_memwr", bus.memwr, 1'b0);
        @(negedge clk);
        checkOutput("t1_memwr",     bus.memwr,     1'b1);
        checkOutput("t1_client_id", bus.client_id, 5'h01);
        checkOutput("t1_amount",    bus.amount,    32'h1);
        for (int i = 0; i < SETTLE; i++) begin
            @(negedge clk);
            checkOutput("t1_settle_memwr", bus.memwr,      1'b0);
            checkOutput("t1_settle_valid", bus.resp_valid, 1'b0);
        end
        @(negedge clk);
        checkOutput("t1_resp_valid",  bus.resp_valid,     1'b1);
        checkOutput("t1_resp_client", bus.resp_client_id, 5'h01);
        checkOutput("t1_resp_canc",   bus.resp_cancelled, 32'h7);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        wait_idle("t1_drain", 20);

        // Back-to-back orders issue in order with their own amounts.
        $display("[TB] back-to-back orders");
        issue_log.delete();
        resp_log.delete();
        cancel_const = 32'h55;
        applyStimulus(5'h1B, 32'hC5);
        applyStimulus(5'h1B, 32'h5C5);
        wait_idle("t2_drain", 40);
        checkOutput("t2_issue_count", issue_log.size(), 2);
        checkOutput("t2_issue0",      issue_log[0], {5'h1B, 32'hC5});
        checkOutput("t2_issue1",      issue_log[1], {5'h1B, 32'h5C5});
        checkOutput("t2_resp_count",  resp_log.size(), 2);

        // Backpressure: one in flight plus four buffered fills the block; the sixth waits.
        $display("[TB] buffer full with response held");
        issue_log.delete();
        resp_log.delete();
        bus.resp_ready = 1'b0;
        cancel_sweep   = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    applyStimulus(5'(i + 3), 32'h100 + 32'(i));
                    if (i == 4) begin
                        @(negedge clk);
                        checkOutput("t3_full_in_ready", bus.in_ready, 1'b0);
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                repeat (30) @(posedge clk);
                #1;
                bus.resp_ready = 1'b1;
            end
        join
        wait_idle("t3_drain", 200);
        checkOutput("t3_resp_count", resp_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("t3_resp%0d_client", i), resp_log[i].c, 5'(i + 3));
            checkOutput($sformatf("t3_issue%0d_amount", i), issue_log[i].a, 32'h100 + 32'(i));
        end
        cancel_sweep = 1'b0;

        // Response held off for ten cycles: stays valid and stable, nothing else issues.
        $display("[TB] stalled response");
        issue_log.delete();
        resp_log.delete();
        bus.resp_ready = 1'b0;
        cancel_const   = 32'hABCD;
        applyStimulus(5'h0A, 32'h10);
        applyStimulus(5'h0B, 32'h20);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.resp_valid !== 1'b1 && n < 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid",  bus.resp_valid,     1'b1);
            checkOutput("t4_hold_client", bus.resp_client_id, 5'h0A);
            checkOutput("t4_hold_canc",   bus.resp_cancelled, 32'hABCD);
            checkOutput("t4_hold_memwr",  bus.memwr,          1'b0);
        end
        checkOutput("t4_issue_before_accept", issue_log.size(), 1);
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b1;
        wait_idle("t4_drain", 40);
        checkOutput("t4_issue_count", issue_log.size(), 2);
        checkOutput("t4_resp1_client", resp_log[1].c, 5'h0B);

        // Reset while settling with two orders buffered discards everything.
        $display("[TB] reset during settle");
        issue_log.delete();
        resp_log.delete();
        applyStimulus(5'h11, 32'h1);
        applyStimulus(5'h12, 32'h2);
        applyStimulus(5'h13, 32'h3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_in_ready",   bus.in_ready,       1'b1);
        checkOutput("t5_memwr",      bus.memwr,          1'b0);
        checkOutput("t5_resp_valid", bus.resp_valid,     1'b0);
        checkOutput("t5_busy",       busy,               1'b0);
        checkOutput("t5_client_id",  bus.client_id,      '0);
        checkOutput("t5_amount",     bus.amount,         '0);
        checkOutput("t5_resp_canc",  bus.resp_cancelled, '0);
        repeat (15) @(negedge clk);
        checkOutput("t5_issue_count", issue_log.size(), 1);
        checkOutput("t5_resp_count",  resp_log.size(),  0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
